// File: rtl/alu_pkg.sv
// Shared types and widths for the 4-bit ALU path: function codes,
// operand/result widths and the sequencer state encoding.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int RES_W  = 8;

    typedef enum logic [1:0] {
        FN_ADD = 2'b00,
        FN_OR  = 2'b01,
        FN_AND = 2'b10,
        FN_CAT = 2'b11
    } alu_func_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between the switch/key logic, the
// sequencer and the display path.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 8
) ();
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    alu_func_t         in_func;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_b_sel;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_result;

    // Requester/consumer side
    modport master (
        output in_valid, in_func, in_a, in_b, in_b_sel, out_ready,
        input  in_ready, out_valid, out_result
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_func, in_a, in_b, in_b_sel, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/alu.sv
// The external combinational 4-bit ALU driven by the sequencer.
module alu #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 8
) (
    input  alu_pkg::alu_func_t func,
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    output logic [RES_W-1:0]   result
);
    import alu_pkg::*;

    always_comb begin
        result = '0;
        unique case (func)
            FN_ADD: result = RES_W'(a) + RES_W'(b);
            FN_OR:  result = RES_W'(|{a, b});
            FN_AND: result = RES_W'(&{a, b});
            FN_CAT: result = RES_W'({a, b});
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for the external ALU: accepts one request, registers the ALU
// inputs, captures the result into out_result/acc and holds it until taken.
module alu_op_sequencer #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    alu_op_sequencer_if.slave    bus,
    input  logic                 acc_clr,
    output alu_pkg::alu_func_t   alu_func,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    input  logic [RES_W-1:0]     alu_result,
    output logic [RES_W-1:0]     acc,
    output logic [CNT_W-1:0]     op_count,
    output logic                 busy
);
    import alu_pkg::*;

    seq_state_t        state_q, state_d;
    logic              accept;
    logic [RES_W-1:0]  acc_eff;
    logic [DATA_W-1:0] b_sel;
    logic [RES_W-1:0]  out_result_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = EXEC;
            EXEC:                       state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    assign accept = (state_q == IDLE) && bus.in_valid;

    // A clear coinciding with an accept feeds the cleared value to B.
    assign acc_eff = acc_clr ? '0 : acc;
    assign b_sel   = bus.in_b_sel ? acc_eff[DATA_W-1:0] : bus.in_b;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alu_func <= FN_ADD;
            alu_a    <= '0;
            alu_b    <= '0;
        end else if (accept) begin
            alu_func <= bus.in_func;
            alu_a    <= bus.in_a;
            alu_b    <= b_sel;
        end
    end

    // The EXEC capture takes priority over a simultaneous acc_clr.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_result_q <= '0;
            acc          <= '0;
            op_count     <= '0;
        end else if (state_q == EXEC) begin
            out_result_q <= alu_result;
            acc          <= alu_result;
            op_count     <= op_count + 1'b1;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = out_result_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: sequencer plus the ALU, checking handshake, results,
// accumulator chaining/clear, async reset and op_count wrap.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic       clk;
    logic       resetn;
    logic       acc_clr;
    alu_func_t  alu_func;
    logic [3:0] alu_a, alu_b;
    logic [7:0] alu_result, acc, op_count;
    logic       busy;

    int unsigned passed = 0;
    int unsigned total  = 0;

    alu_op_sequencer_if #(.DATA_W(4), .RES_W(8)) bus ();

    alu_op_sequencer #(.DATA_W(4), .RES_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .acc_clr    (acc_clr),
        .alu_func   (alu_func),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .acc        (acc),
        .op_count   (op_count),
        .busy       (busy)
    );

    alu #(.DATA_W(4), .RES_W(8)) u_alu (
        .func   (alu_func),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Accept edge then EXEC capture edge; leaves the FSM in DONE.
    task automatic run_op(input alu_func_t f, input logic [3:0] a, input logic [3:0] b,
                          input logic bsel, input logic clr);
        bus.in_valid = 1'b1;
        bus.in_func  = f;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_b_sel = bsel;
        acc_clr      = clr;
        tick();
        bus.in_valid = 1'b0;
        acc_clr      = 1'b0;
        tick();
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
    endtask

    initial begin
        resetn        = 1'b0;
        acc_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_func   = FN_ADD;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_b_sel  = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_acc", acc, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        resetn = 1'b1;
        tick();

        // 9 + 8, latency checks
        bus.in_valid = 1'b1; bus.in_func = FN_ADD; bus.in_a = 4'h9; bus.in_b = 4'h8; bus.in_b_sel = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("t1_exec_busy", busy, 1);
        chk("t1_exec_in_ready", bus.in_ready, 0);
        chk("t1_exec_out_valid", bus.out_valid, 0);
        chk("t1_alu_a", alu_a, 4'h9);
        chk("t1_alu_b", alu_b, 4'h8);
        tick();
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_result", bus.out_result, 8'h11);
        chk("t1_acc", acc, 8'h11);
        chk("t1_op_count", op_count, 1);
        take();
        chk("t1_back_idle", bus.in_ready, 1);
        chk("t1_out_valid_drop", bus.out_valid, 0);

        // chained B from acc low nibble
        run_op(FN_ADD, 4'h1, 4'h7, 1'b1, 1'b0);
        chk("t2_alu_b", alu_b, 4'h1);
        chk("t2_out_result", bus.out_result, 8'h02);
        chk("t2_acc", acc, 8'h02);
        take();

        run_op(FN_CAT, 4'h3, 4'hC, 1'b0, 1'b0);
        chk("t3_cat", bus.out_result, 8'h3C);
        take();
        run_op(FN_OR, 4'h0, 4'h0, 1'b0, 1'b0);
        chk("t3_or", bus.out_result, 8'h00);
        take();
        run_op(FN_AND, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("t3_and", bus.out_result, 8'h01);
        take();
        run_op(FN_ADD, 4'hF, 4'hF, 1'b0, 1'b0);
        chk("t3_add_max", bus.out_result, 8'h1E);
        take();

        // consumer backpressure with a competing request
        run_op(FN_ADD, 4'h2, 4'h3, 1'b0, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_func = FN_CAT; bus.in_a = 4'hA; bus.in_b = 4'hB;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_out_valid", bus.out_valid, 1);
            chk("t4_hold_result", bus.out_result, 8'h05);
            chk("t4_hold_in_ready", bus.in_ready, 0);
        end
        chk("t4_alu_a_held", alu_a, 4'h2);
        chk("t4_op_count", op_count, 7);
        bus.in_valid = 1'b0;
        take();
        chk("t4_release_in_ready", bus.in_ready, 1);
        chk("t4_release_out_valid", bus.out_valid, 0);

        // async reset during EXEC
        bus.in_valid = 1'b1; bus.in_func = FN_ADD; bus.in_a = 4'h4; bus.in_b = 4'h4; bus.in_b_sel = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("t5_in_exec", busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_in_ready", bus.in_ready, 1);
        chk("t5_async_acc", acc, 0);
        chk("t5_async_out_result", bus.out_result, 0);
        chk("t5_async_op_count", op_count, 0);
        chk("t5_async_alu_a", alu_a, 0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_out_valid", bus.out_valid, 0);
        end

        // acc_clr with chained accept, and clear interactions
        run_op(FN_ADD, 4'h9, 4'h8, 1'b0, 1'b0);
        take();
        chk("t6_acc_pre", acc, 8'h11);
        run_op(FN_ADD, 4'h5, 4'h6, 1'b1, 1'b1);
        chk("t6_clr_alu_b", alu_b, 4'h0);
        chk("t6_clr_result", bus.out_result, 8'h05);
        take();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("t6_idle_clr_acc", acc, 0);
        chk("t6_idle_clr_keeps_result", bus.out_result, 8'h05);
        bus.in_valid = 1'b1; bus.in_func = FN_ADD; bus.in_a = 4'h1; bus.in_b = 4'h2; bus.in_b_sel = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("t6_capture_wins", acc, 8'h03);
        take();

        // op_count wrap from a clean reset
        resetn = 1'b0;
        #2 resetn = 1'b1;
        tick();
        for (int i = 0; i < 255; i++) begin
            run_op(FN_ADD, 4'h1, 4'h1, 1'b0, 1'b0);
            take();
        end
        chk("t6_count_255", op_count, 8'hFF);
        run_op(FN_ADD, 4'h1, 4'h1, 1'b0, 1'b0);
        chk("t6_count_wrap", op_count, 8'h00);
        take();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator side of the 4-bit ALU interface. Accepts operation requests over a valid/ready handshake, drives func/a/b into the external combinational ALU from registers, and captures the 8-bit result. It holds the result for a downstream consumer and keeps an accumulator, so the B operand can be chained from the previous result. It sits between the switch/key input logic and the display path.

Parameters:
DATA_W, 4, operand width; must match the ALU operand width
RES_W, 8, result width; fixed at 2*DATA_W
CNT_W, 8, width of the completed-operation counter

Ports:
clk  input  1  clock; all state updates on the rising edge
resetn  input  1  asynchronous, active-low reset
in_valid  input  1  request present
in_ready  output  1  sequencer can accept a request
in_func  input  2  ALU function code: 00 add, 01 OR-reduce, 10 AND-reduce, 11 concat {a,b}
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B, used when in_b_sel=0
in_b_sel  input  1  1: B = acc[DATA_W-1:0]; 0: B = in_b
acc_clr  input  1  synchronous accumulator clear
alu_func  output  2  to ALU func
alu_a  output  DATA_W  to ALU a
alu_b  output  DATA_W  to ALU b
alu_result  input  RES_W  from ALU output
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out_result  output  RES_W  captured result
acc  output  RES_W  accumulator, equals last captured result unless cleared
op_count  output  CNT_W  number of completed operations, wraps
busy  output  1  high in EXEC or DONE

Behaviour:
- FSM states: IDLE, EXEC, DONE.
- Reset (async, resetn=0):
  - state=IDLE; alu_func, alu_a, alu_b, out_result, acc and op_count all 0.
  - out_valid=0, in_ready=1, busy=0.
  - Reset takes effect immediately, including mid-operation; the in-flight operation is discarded and no result is delivered.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, register func, a and B into the alu_* registers and go to EXEC.
  - B = in_b_sel ? acc[DATA_W-1:0] : in_b.
- EXEC:
  - in_ready=0; the ALU inputs are stable for the whole cycle.
  - At the next edge: out_result <= alu_result; acc <= alu_result; op_count <= op_count+1 (255 wraps to 0); go to DONE.
- DONE:
  - out_valid=1; out_result and acc are held stable.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
  - With out_ready=0 the state holds indefinitely.
- Latency: accepted at edge T, out_valid high after edge T+1. Minimum issue interval is 3 cycles (accept, EXEC, DONE handshake).
- in_ready and out_valid are pure functions of state (Moore). There is no combinational path from in_valid or out_ready to any output.
- alu_* outputs change only on the accept edge; between operations they hold the last values.
- acc_clr:
  - Clears acc at the edge, in any state except the EXEC capture edge. On that edge the capture wins and acc_clr is ignored.
  - acc_clr together with an accept edge and in_b_sel=1: B uses the cleared value 0.
  - acc_clr never changes out_result.
- in_valid asserted outside IDLE is ignored; the requester must hold the request until in_ready.
- Width rules: the result is captured as-is at RES_W bits with no sign extension. The accumulator feedback uses the low DATA_W bits only.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_func_t (2-bit enum FN_ADD=00, FN_OR=01, FN_AND=10, FN_CAT=11).
  - constants DATA_W=4 and RES_W=8.
  - typedef seq_state_t {IDLE, EXEC, DONE}.
- No sub-module is required: the FSM and registers form one module.
- The bench instantiates the existing ALU alongside the sequencer, connected by the alu_* and alu_result ports.

Test Plan:
1. Reset, then in_func=00, in_a=9, in_b=8, in_b_sel=0, out_ready=1 -> out_valid after 2 edges, out_result=8'h11, acc=8'h11, op_count=1.
2. Following 1: in_func=00, in_a=1, in_b_sel=1 -> alu_b=4'h1, out_result=8'h02, acc=8'h02.
3. in_func=11, in_a=3, in_b=C -> out_result=8'h3C. Then in_func=01 with a=0, b=0 -> 8'h00. Then in_func=10 with a=F, b=F -> 8'h01.
4. out_ready held 0 for 5 cycles in DONE -> out_valid=1, out_result stable, in_ready=0, and a new in_valid is ignored. Raising out_ready returns the FSM to IDLE next edge.
5. resetn pulsed low during EXEC -> outputs go to 0 asynchronously, state is IDLE, and out_valid never asserts for that operation.
6. acc_clr with accept and in_b_sel=1 after acc=8'h11 -> alu_b=0. Separately, 256 completed operations -> op_count wraps to 0.
